// File: rtl/dmem_arb_pkg.sv
// Shared FSM encoding, port indices and counter sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT_CU   = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int unsigned LAT_MAX = 4;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus the single-port memory bus seen by the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_pick2.sv
// Combinational two-way winner select; DMEM_ARB_RR_EN selects round-robin,
// otherwise port 0 has fixed priority.
module arb_pick2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid_c,
  output logic grant_c
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    grant_valid_c = req0 | req1;
    grant_c       = PORT_CU;
    if (req0 && req1) begin
      grant_c = ~last_owner;
    end else if (req1) begin
      grant_c = PORT_HOST;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_valid_c = req0 | req1;
    grant_c       = PORT_CU;
    if (!req0 && req1) begin
      grant_c = PORT_HOST;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CU (port 0) and host (port 1) transactions onto the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin on contested grants; default is fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  arb_state_e        state, state_n;
  logic              owner, owner_n;
  logic              last_owner;
  logic              lat_we, lat_we_n;
  logic [ADDR_W-1:0] lat_addr, lat_addr_n;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] rdata_n;
  logic              ack0_n, ack1_n, busy_n, mem_en_n, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              grant_valid_c, grant_c;

`ifdef DMEM_ARB_RR_EN
  logic last_owner_n;
`else
  assign last_owner = PORT_HOST;
`endif

  arb_pick2 u_pick (
    .req0          (bus.req0),
    .req1          (bus.req1),
    .last_owner    (last_owner),
    .grant_valid_c (grant_valid_c),
    .grant_c       (grant_c)
  );

  // Next-state, latches and the registered-output values derived from the next state
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    lat_we_n    = lat_we;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    cnt_n       = cnt;
    rdata_n     = bus.rdata;
`ifdef DMEM_ARB_RR_EN
    last_owner_n = last_owner;
`endif

    case (state)
      IDLE: begin
        if (grant_valid_c) begin
          owner_n     = grant_c;
          lat_we_n    = (grant_c == PORT_HOST) ? bus.we1    : bus.we0;
          lat_addr_n  = (grant_c == PORT_HOST) ? bus.addr1  : bus.addr0;
          lat_wdata_n = (grant_c == PORT_HOST) ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_RR_EN
          last_owner_n = grant_c;
`endif
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          state_n = RESP;
        end else begin
          cnt_n   = CNT_W'(READ_LAT - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          rdata_n = bus.mem_rdata;
          state_n = RESP;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n      = (state_n != IDLE);
    mem_en_n    = (state_n == ISSUE);
    mem_we_n    = mem_en_n & lat_we_n;
    mem_addr_n  = mem_en_n ? lat_addr_n  : '0;
    mem_wdata_n = mem_en_n ? lat_wdata_n : '0;
    ack0_n      = (state_n == RESP) && (owner_n == PORT_CU);
    ack1_n      = (state_n == RESP) && (owner_n == PORT_HOST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= PORT_CU;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      cnt           <= '0;
`ifdef DMEM_ARB_RR_EN
      last_owner    <= PORT_HOST;
`endif
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.rdata     <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      lat_we        <= lat_we_n;
      lat_addr      <= lat_addr_n;
      lat_wdata     <= lat_wdata_n;
      cnt           <= cnt_n;
`ifdef DMEM_ARB_RR_EN
      last_owner    <= last_owner_n;
`endif
      bus.ack0      <= ack0_n;
      bus.ack1      <= ack1_n;
      bus.busy      <= busy_n;
      bus.rdata     <= rdata_n;
      bus.mem_en    <= mem_en_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle table on a READ_LAT=1 instance, hand sequences
// for latency and mid-read reset on a READ_LAT=4 instance.
module tb_dmem_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
  } vin_t;

  typedef struct packed {
    logic          ack0;
    logic          ack1;
    logic          busy;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vexp_t;

  typedef struct packed {
    vin_t  i;
    vexp_t e;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   nv;
  vec_t vecs [64];

  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b4 ();

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_dut1 (
    .clk (clk), .reset_n (reset_n), .bus (b1.slave)
  );
  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(4)) u_dut4 (
    .clk (clk), .reset_n (reset_n), .bus (b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: writes on the enable edge, read data valid READ_LAT cycles later
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem4 [256];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe4 [4];

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    pipe1 <= mem1[b1.mem_addr];
    if (b4.mem_en && b4.mem_we) mem4[b4.mem_addr] <= b4.mem_wdata;
    pipe4[0] <= mem4[b4.mem_addr];
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
    pipe4[3] <= pipe4[2];
  end
  assign b1.mem_rdata = pipe1;
  assign b4.mem_rdata = pipe4[3];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic vin_t vin(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                               logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1);
    vin_t v;
    v = '{r0, w0, a0, d0, r1, w1, a1, d1};
    return v;
  endfunction

  function automatic vexp_t vexp(logic a0, logic a1, logic bz, logic en, logic we,
                                 logic [AW-1:0] ad, logic [DW-1:0] wd, logic [DW-1:0] rd);
    vexp_t v;
    v = '{a0, a1, bz, en, we, ad, wd, rd};
    return v;
  endfunction

  task automatic add(input vin_t i, input vexp_t e);
    vecs[nv].i = i;
    vecs[nv].e = e;
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive1(input vin_t v);
    b1.req0 = v.r0; b1.we0 = v.w0; b1.addr0 = v.a0; b1.wdata0 = v.d0;
    b1.req1 = v.r1; b1.we1 = v.w1; b1.addr1 = v.a1; b1.wdata1 = v.d1;
  endtask

  // Counts edges from the IDLE sampling edge until the given port's ack (0 = timeout)
  task automatic wait_ack4(input logic port, output int lat, output int ens, output int other);
    lat = 0; ens = 0; other = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b4.mem_en) ens++;
      if (port ? b4.ack0 : b4.ack1) other++;
      if (port ? b4.ack1 : b4.ack0) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    vin_t idle_i;
    vin_t cont;
    int   w;
    int   lat, ens, other;

    checks = 0; errors = 0; nv = 0;
    reset_n = 1'b0;
    idle_i = vin(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);
    drive1(idle_i);
    b4.req0 = L; b4.we0 = L; b4.addr0 = '0; b4.wdata0 = '0;
    b4.req1 = L; b4.we1 = L; b4.addr1 = '0; b4.wdata1 = '0;

    // Single write, single read, operand change while waiting, read-back
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h0000));
    add(vin(H, H, 8'h10, 16'hBEEF, L, L, 8'h00, 16'h0000), vexp(L, L, H, H, H, 8'h10, 16'hBEEF, 16'h0000));
    add(vin(H, H, 8'h10, 16'hBEEF, L, L, 8'h00, 16'h0000), vexp(H, L, H, L, L, 8'h00, 16'h0000, 16'h0000));
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h0000));
    add(vin(L, L, 8'h00, 16'h0000, H, L, 8'h10, 16'h0000), vexp(L, L, H, H, L, 8'h10, 16'h0000, 16'h0000));
    add(vin(L, L, 8'h00, 16'h0000, H, L, 8'h10, 16'h0000), vexp(L, L, H, L, L, 8'h00, 16'h0000, 16'h0000));
    add(vin(L, L, 8'h00, 16'h0000, H, L, 8'h10, 16'h0000), vexp(L, H, H, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(vin(H, H, 8'h30, 16'h1111, H, H, 8'h20, 16'h2222), vexp(L, L, H, H, H, 8'h30, 16'h1111, 16'hBEEF));
    add(vin(H, H, 8'h30, 16'h1111, H, H, 8'h21, 16'h2222), vexp(H, L, H, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(vin(L, L, 8'h00, 16'h0000, H, H, 8'h21, 16'h2222), vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(vin(L, L, 8'h00, 16'h0000, H, H, 8'h21, 16'h2222), vexp(L, L, H, H, H, 8'h21, 16'h2222, 16'hBEEF));
    add(vin(L, L, 8'h00, 16'h0000, H, H, 8'h21, 16'h2222), vexp(L, H, H, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(vin(L, L, 8'h00, 16'h0000, H, L, 8'h21, 16'h0000), vexp(L, L, H, H, L, 8'h21, 16'h0000, 16'hBEEF));
    add(vin(L, L, 8'h00, 16'h0000, H, L, 8'h21, 16'h0000), vexp(L, L, H, L, L, 8'h00, 16'h0000, 16'hBEEF));
    add(vin(L, L, 8'h00, 16'h0000, H, L, 8'h21, 16'h0000), vexp(L, H, H, L, L, 8'h00, 16'h0000, 16'h2222));
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h2222));

    // Both ports held back-to-back: last grant was port 1, so port 0 wins first
    cont = vin(H, H, 8'h40, 16'hAAAA, H, H, 8'h41, 16'hBBBB);
    for (int g = 0; g < 4; g++) begin
`ifdef DMEM_ARB_RR_EN
      w = g % 2;
`else
      w = 0;
`endif
      add(cont, vexp(L, L, H, H, H, (w == 1) ? 8'h41 : 8'h40, (w == 1) ? 16'hBBBB : 16'hAAAA, 16'h2222));
      add(cont, vexp((w == 0), (w == 1), H, L, L, 8'h00, 16'h0000, 16'h2222));
      add(cont, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h2222));
    end
    add(vin(L, L, 8'h00, 16'h0000, H, H, 8'h41, 16'hBBBB), vexp(L, L, H, H, H, 8'h41, 16'hBBBB, 16'h2222));
    add(vin(L, L, 8'h00, 16'h0000, H, H, 8'h41, 16'hBBBB), vexp(L, H, H, L, L, 8'h00, 16'h0000, 16'h2222));
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h2222));

    // Port 0 alone, two writes back-to-back: ISSUE every 3 cycles
    add(vin(H, H, 8'h50, 16'h5555, L, L, 8'h00, 16'h0000), vexp(L, L, H, H, H, 8'h50, 16'h5555, 16'h2222));
    add(vin(H, H, 8'h50, 16'h5555, L, L, 8'h00, 16'h0000), vexp(H, L, H, L, L, 8'h00, 16'h0000, 16'h2222));
    add(vin(H, H, 8'h51, 16'h6666, L, L, 8'h00, 16'h0000), vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h2222));
    add(vin(H, H, 8'h51, 16'h6666, L, L, 8'h00, 16'h0000), vexp(L, L, H, H, H, 8'h51, 16'h6666, 16'h2222));
    add(vin(H, H, 8'h51, 16'h6666, L, L, 8'h00, 16'h0000), vexp(H, L, H, L, L, 8'h00, 16'h0000, 16'h2222));
    add(idle_i, vexp(L, L, L, L, L, 8'h00, 16'h0000, 16'h2222));

    // Reset values while held in reset
    @(posedge clk); #1;
    chk("rst busy", 0, 32'(b1.busy), 32'(0));
    chk("rst ack0", 0, 32'(b1.ack0), 32'(0));
    chk("rst ack1", 0, 32'(b1.ack1), 32'(0));
    chk("rst mem_en", 0, 32'(b1.mem_en), 32'(0));
    chk("rst mem_addr", 0, 32'(b1.mem_addr), 32'(0));
    chk("rst rdata", 0, 32'(b1.rdata), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive1(vecs[i].i);
      @(posedge clk); #1;
      chk("ack0", i, 32'(b1.ack0), 32'(vecs[i].e.ack0));
      chk("ack1", i, 32'(b1.ack1), 32'(vecs[i].e.ack1));
      chk("busy", i, 32'(b1.busy), 32'(vecs[i].e.busy));
      chk("mem_en", i, 32'(b1.mem_en), 32'(vecs[i].e.en));
      chk("mem_we", i, 32'(b1.mem_we), 32'(vecs[i].e.we));
      chk("mem_addr", i, 32'(b1.mem_addr), 32'(vecs[i].e.addr));
      chk("mem_wdata", i, 32'(b1.mem_wdata), 32'(vecs[i].e.wdata));
      chk("rdata", i, 32'(b1.rdata), 32'(vecs[i].e.rdata));
    end

    // READ_LAT=4: write then read, ack at s+2 and s+6
    b4.req0 = H; b4.we0 = H; b4.addr0 = 8'h55; b4.wdata0 = 16'hCAFE;
    wait_ack4(L, lat, ens, other);
    chk("l4 write lat", 0, 32'(lat), 32'(2));
    chk("l4 write en count", 0, 32'(ens), 32'(1));
    b4.req0 = L;
    @(posedge clk); #1;
    b4.req1 = H; b4.we1 = L; b4.addr1 = 8'h55;
    wait_ack4(H, lat, ens, other);
    chk("l4 read lat", 0, 32'(lat), 32'(6));
    chk("l4 read en count", 0, 32'(ens), 32'(1));
    chk("l4 read other ack", 0, 32'(other), 32'(0));
    chk("l4 read rdata", 0, 32'(b4.rdata), 32'(16'hCAFE));
    b4.req1 = L;
    @(posedge clk); #1;

    // Reset asserted in WAIT: outputs clear at once, no ack, then a re-issued read completes
    b4.req0 = H; b4.we0 = L; b4.addr0 = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre-rst busy", 0, 32'(b4.busy), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("mid-rst busy", 0, 32'(b4.busy), 32'(0));
    chk("mid-rst ack0", 0, 32'(b4.ack0), 32'(0));
    chk("mid-rst mem_en", 0, 32'(b4.mem_en), 32'(0));
    chk("mid-rst rdata", 0, 32'(b4.rdata), 32'(0));
    chk("mid-rst l1 rdata", 0, 32'(b1.rdata), 32'(0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("in-rst ack0", k, 32'(b4.ack0), 32'(0));
      chk("in-rst busy", k, 32'(b4.busy), 32'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_ack4(L, lat, ens, other);
    chk("post-rst read lat", 0, 32'(lat), 32'(6));
    chk("post-rst rdata", 0, 32'(b4.rdata), 32'(16'hCAFE));
    chk("post-rst other ack", 0, 32'(other), 32'(0));
    b4.req0 = L;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
